// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light phase countdown: light codes,
// FSM encoding and the decimal-to-BCD helper used on the duration parameters.
package tlc_pkg;

  localparam logic [1:0] TL_RED     = 2'd0;
  localparam logic [1:0] TL_YELLOW  = 2'd1;
  localparam logic [1:0] TL_GREEN   = 2'd2;
  localparam logic [1:0] TL_INVALID = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // 0..99 to packed two-digit BCD {tens, ones}
  function automatic logic [7:0] dec2bcd(input int unsigned v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

endpackage

// File: rtl/bcd_down_counter_2d.sv
// Two-digit BCD down counter with synchronous load; owns the ones->tens borrow.
module bcd_down_counter_2d (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       zero
);

  assign zero = (tens == 4'd0) && (ones == 4'd0);

  // Decrement is ignored at 00 so the count can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (load) begin
      tens <= load_val[7:4];
      ones <= load_val[3:0];
    end else if (dec && !zero) begin
      if (ones != 4'd0) begin
        ones <= ones - 4'd1;
      end else begin
        ones <= 4'd9;
        tens <= tens - 4'd1;
      end
    end
  end

endmodule

// File: rtl/tlc_phase_countdown.sv
// Per-light "seconds remaining" readout: reloads on every light-code change
// and counts down in BCD once per tick, holding at 00 or showing EE on a bad code.
module tlc_phase_countdown
  import tlc_pkg::*;
#(
  parameter int RED_SEC           = 15,
  parameter int YELLOW_SEC        = 3,
  parameter int GREEN_PEAK_SEC    = 20,
  parameter int GREEN_OFFPEAK_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] tl,
  input  logic       peak,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       valid,
  output logic       overrun
);

  localparam logic [7:0] RED_BCD       = dec2bcd(RED_SEC);
  localparam logic [7:0] YELLOW_BCD    = dec2bcd(YELLOW_SEC);
  localparam logic [7:0] GREEN_PK_BCD  = dec2bcd(GREEN_PEAK_SEC);
  localparam logic [7:0] GREEN_OFF_BCD = dec2bcd(GREEN_OFFPEAK_SEC);
  localparam logic [7:0] ERR_BCD       = 8'hEE;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] tl_q;
  logic       first;
  logic       change;
  logic       cnt_zero;
  logic       cnt_dec;
  logic [7:0] load_val;

  assign change = first || (tl != tl_q);

  // Peak is only looked at here, so mid-phase toggles never reach the count.
  always_comb begin
    load_val = ERR_BCD;
    case (tl)
      TL_RED:    load_val = RED_BCD;
      TL_YELLOW: load_val = YELLOW_BCD;
      TL_GREEN:  load_val = peak ? GREEN_PK_BCD : GREEN_OFF_BCD;
      default:   load_val = ERR_BCD;
    endcase
  end

  assign cnt_dec = (state == ST_RUN) && !change && tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      tl_q  <= TL_RED;
      first <= 1'b1;
    end else begin
      state <= state_nxt;
      tl_q  <= tl;
      first <= 1'b0;
    end
  end

  // A change event always wins over a same-cycle tick.
  always_comb begin
    state_nxt = state;
    if (change) begin
      state_nxt = (tl == TL_INVALID) ? ST_ERR : ST_RUN;
    end else begin
      case (state)
        ST_RUN:  if (tick && cnt_zero) state_nxt = ST_HOLD;
        ST_HOLD: state_nxt = ST_HOLD;
        ST_ERR:  state_nxt = ST_ERR;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    valid   = 1'b0;
    overrun = 1'b0;
    case (state)
      ST_RUN:  valid = 1'b1;
      ST_HOLD: begin
        valid   = 1'b1;
        overrun = 1'b1;
      end
      default: begin
        valid   = 1'b0;
        overrun = 1'b0;
      end
    endcase
  end

  bcd_down_counter_2d u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (change),
    .load_val (load_val),
    .dec      (cnt_dec),
    .tens     (bcd_tens),
    .ones     (bcd_ones),
    .zero     (cnt_zero)
  );

endmodule

// File: tb/tb_tlc_phase_countdown.sv
// Directed and randomized bench for tlc_phase_countdown against a seconds-level model.
module tb_tlc_phase_countdown;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] tl = 2'd0;
  logic       peak = 1'b0;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       valid;
  logic       overrun;

  int checks = 0;
  int failures = 0;

  // Model: remaining seconds as an integer plus a few flags.
  int m_rem = 0;
  bit m_live = 0;
  bit m_over = 0;
  bit m_err = 0;
  bit m_first = 1;
  int m_prev = 0;

  tlc_phase_countdown dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .tl       (tl),
    .peak     (peak),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones),
    .valid    (valid),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  function automatic int duration(input int code, input bit pk);
    case (code)
      0:       return 15;
      1:       return 3;
      default: return pk ? 20 : 10;
    endcase
  endfunction

  function automatic logic [9:0] model_out();
    logic [3:0] t;
    logic [3:0] o;
    if (m_err) return {4'hE, 4'hE, 2'b00};
    if (!m_live) return 10'd0;
    t = 4'(m_rem / 10);
    o = 4'(m_rem % 10);
    return {t, o, 1'b1, m_over};
  endfunction

  task automatic model_reset();
    m_rem = 0; m_live = 0; m_over = 0; m_err = 0; m_first = 1; m_prev = 0;
  endtask

  task automatic model_edge();
    int code;
    code = int'(tl);
    if (m_first || code != m_prev) begin
      if (code == 3) begin
        m_err = 1; m_live = 0; m_over = 0;
      end else begin
        m_err = 0; m_live = 1; m_over = 0;
        m_rem = duration(code, peak);
      end
    end else if (m_live && !m_over && tick) begin
      if (m_rem > 0) m_rem = m_rem - 1;
      else m_over = 1;
    end
    m_prev = code;
    m_first = 0;
  endtask

  task automatic check(input string tag, input logic [9:0] exp);
    logic [9:0] got;
    got = {bcd_tens, bcd_ones, valid, overrun};
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got tens/ones/valid/overrun=%h/%h/%b/%b expected %h/%h/%b/%b",
             tag, got[9:6], got[5:2], got[1], got[0], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Drive inputs, take one edge, update the model, and compare 1 time unit later.
  task automatic step(input bit tk, input logic [1:0] code, input bit pk, input string tag);
    tick = tk; tl = code; peak = pk;
    @(posedge clk);
    model_edge();
    #1;
    check(tag, model_out());
  endtask

  initial begin
    // Reset held across two edges
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 10'd0);
    reset = 1'b0;
    model_reset();

    // Red countdown to 00 then HOLD, tick every cycle
    step(1, 2'd0, 0, "red_load");
    check("red_load_const", {4'd1, 4'd5, 1'b1, 1'b0});
    for (int i = 0; i < 15; i++) step(1, 2'd0, 0, "red_count");
    check("red_zero_const", {4'd0, 4'd0, 1'b1, 1'b0});
    step(1, 2'd0, 0, "red_hold");
    check("red_hold_const", {4'd0, 4'd0, 1'b1, 1'b1});
    step(1, 2'd0, 0, "red_hold_stay");

    // Borrow on peak green
    step(1, 2'd2, 1, "green_pk_load");
    check("green_pk_const", {4'd2, 4'd0, 1'b1, 1'b0});
    step(1, 2'd2, 1, "borrow_19");
    check("borrow_19_const", {4'd1, 4'd9, 1'b1, 1'b0});
    for (int i = 0; i < 9; i++) step(1, 2'd2, 1, "green_count");
    check("at_10_const", {4'd1, 4'd0, 1'b1, 1'b0});
    step(1, 2'd2, 1, "borrow_09");
    check("borrow_09_const", {4'd0, 4'd9, 1'b1, 1'b0});

    // Change during count, simultaneous tick discarded
    step(0, 2'd0, 0, "red_reload");
    for (int i = 0; i < 3; i++) step(1, 2'd0, 0, "red_3ticks");
    check("red_12_const", {4'd1, 4'd2, 1'b1, 1'b0});
    step(1, 2'd1, 0, "yellow_with_tick");
    check("yellow_tick_lost", {4'd0, 4'd3, 1'b1, 1'b0});

    // Peak sampled only on green load
    step(0, 2'd2, 0, "green_off_load");
    check("green_off_const", {4'd1, 4'd0, 1'b1, 1'b0});
    step(0, 2'd2, 1, "peak_toggle1");
    step(0, 2'd2, 0, "peak_toggle2");
    step(1, 2'd2, 1, "peak_mid_tick");
    check("peak_mid_const", {4'd0, 4'd9, 1'b1, 1'b0});
    step(0, 2'd0, 1, "to_red");
    step(0, 2'd2, 1, "green_pk_again");
    check("green_pk_again_const", {4'd2, 4'd0, 1'b1, 1'b0});

    // Invalid code then recovery
    step(1, 2'd3, 0, "invalid");
    check("invalid_const", {4'hE, 4'hE, 1'b0, 1'b0});
    step(1, 2'd3, 0, "invalid_hold");
    step(1, 2'd1, 0, "recover_yellow");
    check("recover_const", {4'd0, 4'd3, 1'b1, 1'b0});

    // Async reset mid-count at 07
    step(0, 2'd0, 0, "red_for_reset");
    for (int i = 0; i < 8; i++) step(1, 2'd0, 0, "red_to_07");
    check("at_07_const", {4'd0, 4'd7, 1'b1, 1'b0});
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_reset", model_out());
    check("async_reset_const", 10'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1, 2'd0, 0, "reload_after_reset");
    check("reload_after_reset_const", {4'd1, 4'd5, 1'b1, 1'b0});

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [1:0] code;
      code = tl;
      if ($urandom_range(0, 9) == 0) code = 2'($urandom_range(0, 3));
      step(bit'($urandom_range(0, 1)), code, bit'($urandom_range(0, 1)), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
